// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the unified-memory SRAM port arbiter: master IDs,
// response-tracker states and the width of the packed SRAM request bus.
package sram_port_arbiter_pkg;

  // Master IDs; also used as bit positions in the one-hot grant vector.
  localparam logic ARB_M0 = 1'b0;  // fetch (read-only)
  localparam logic ARB_M1 = 1'b1;  // execute (load/store)

  // Response tracker: BUSY means a granted access returns data next cycle.
  typedef enum logic {
    TRK_IDLE = 1'b0,
    TRK_BUSY = 1'b1
  } trk_state_e;

  // Packed SRAM request bus: {wr, wstrb[3:0], addr, wdata}.
  function automatic int sram_req_bus_w(input int addr_w, input int data_w);
    return addr_w + data_w + 4 + 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_arb_pick2.sv
// Two-requester one-hot grant picker. Default build: fixed priority M1 > M0.
// With SRAM_ARB_RR_EN defined: round-robin, the master not granted last wins
// on contention (last_grant input present only in that build).
module arb_pick2
  import sram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
`ifdef SRAM_ARB_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

`ifdef SRAM_ARB_RR_EN
  // Round-robin pick: a lone requester always wins, contention goes to the other master.
  always_comb begin
    grant = 2'b00;
    if (req[ARB_M1] && req[ARB_M0]) begin
      if (last_grant == ARB_M1) grant[ARB_M0] = 1'b1;
      else                      grant[ARB_M1] = 1'b1;
    end else begin
      grant = req;
    end
  end
`else
  // Fixed priority pick: execute stage always beats fetch.
  always_comb begin
    grant         = 2'b00;
    grant[ARB_M1] = req[ARB_M1];
    grant[ARB_M0] = req[ARB_M0] & ~req[ARB_M1];
  end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between fetch (M0) and execute (M1).
// One grant per cycle; read data returns one cycle later to the owner recorded
// by the response tracker. Optional round-robin arbitration: SRAM_ARB_RR_EN.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [3:0]        m1_wstrb,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int REQ_BUS_W = sram_req_bus_w(ADDR_W, DATA_W);

  logic [1:0]           req;
  logic [1:0]           grant;
  trk_state_e           state_q, state_d;
  logic                 owner_q, owner_d;
  logic [REQ_BUS_W-1:0] req_bus;
  logic                 gnt_wr;
  logic [3:0]           gnt_wstrb;

  // Requests are masked while reset is high so nothing is granted or written.
  assign req = reset ? 2'b00 : {m1_req, m0_req};

`ifdef SRAM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  arb_pick2 u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Round-robin pointer only moves when somebody is actually granted.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[ARB_M1])      last_grant_d = ARB_M1;
    else if (grant[ARB_M0]) last_grant_d = ARB_M0;
  end

  // Round-robin pointer register; starts at M0 so M1 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= ARB_M0;
    else       last_grant_q <= last_grant_d;
  end
`else
  arb_pick2 u_pick (
    .req   (req),
    .grant (grant)
  );
`endif

  // Tracker next state: any grant makes the next cycle a response cycle.
  always_comb begin
    state_d = TRK_IDLE;
    owner_d = owner_q;
    if (|grant) begin
      state_d = TRK_BUSY;
      owner_d = grant[ARB_M1] ? ARB_M1 : ARB_M0;
    end
  end

  // Tracker registers; reset drops any in-flight response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TRK_IDLE;
      owner_q <= ARB_M0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Granted request onto the SRAM port; fetch never writes.
  assign req_bus = grant[ARB_M1] ? {m1_wr, m1_wstrb, m1_addr, m1_wdata}
                                 : {1'b0, 4'b0000, m0_addr, {DATA_W{1'b0}}};
  assign {gnt_wr, gnt_wstrb, sram_addr, sram_wdata} = req_bus;

  assign sram_en    = |grant;
  assign sram_wen   = gnt_wr ? gnt_wstrb : 4'b0000;
  assign m0_addr_ok = grant[ARB_M0];
  assign m1_addr_ok = grant[ARB_M1];

  // Response routing: read data goes to both, data_ok marks the real owner.
  assign m0_data_ok = (state_q == TRK_BUSY) && (owner_q == ARB_M0);
  assign m1_data_ok = (state_q == TRK_BUSY) && (owner_q == ARB_M1);
  assign m0_rdata   = sram_rdata;
  assign m1_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a response
// scoreboard. Expected arbitration follows SRAM_ARB_RR_EN when defined.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0;
  logic [31:0] m0_addr = '0;
  logic        m0_addr_ok, m0_data_ok;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0;
  logic        m1_wr = 1'b0;
  logic [3:0]  m1_wstrb = '0;
  logic [31:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic        m1_addr_ok, m1_data_ok;
  logic [31:0] m1_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vld;
    logic        owner;
    logic        chkd;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] mem     [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  logic        mdl_last = 1'b0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
    .m1_rdata(m1_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Synchronous SRAM: read data valid the cycle after an enabled access.
  always @(posedge clk) begin
    logic [31:0] w;
    if (sram_en) begin
      w = mem.exists(sram_addr >> 2) ? mem[sram_addr >> 2] : 32'h0;
      sram_rdata <= w;
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
      mem[sram_addr >> 2] = w;
    end
  end

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
  endfunction

  // Expected one-hot grant {M1, M0}.
  function automatic logic [1:0] mdl_grant(input logic r0, input logic r1);
`ifdef SRAM_ARB_RR_EN
    if (r0 && r1) return mdl_last ? 2'b01 : 2'b10;
    return {r1, r0};
`else
    return {r1, r0 & ~r1};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_m0_addr_ok"}, m0_addr_ok, 0);
    check({tag, "_m1_addr_ok"}, m1_addr_ok, 0);
    check({tag, "_m0_data_ok"}, m0_data_ok, 0);
    check({tag, "_m1_data_ok"}, m1_data_ok, 0);
    check({tag, "_sram_en"}, sram_en, 0);
    check({tag, "_sram_wen"}, sram_wen, 0);
  endtask

  task automatic push_idle();
    resp_t n;
    n.vld = 1'b0; n.owner = 1'b0; n.chkd = 1'b0; n.data = '0;
    exp_q.push_back(n);
  endtask

  // One cycle: drive at negedge, check previous response and this cycle's grant.
  task automatic step(input string tag, input logic rel,
                      input logic r0, input logic [31:0] a0,
                      input logic r1, input logic wr, input logic [3:0] st,
                      input logic [31:0] a1, input logic [31:0] wd);
    resp_t      e, n;
    logic [1:0] g;
    @(negedge clk);
    if (rel) reset = 1'b0;
    m0_req = r0; m0_addr = a0;
    m1_req = r1; m1_wr = wr; m1_wstrb = st; m1_addr = a1; m1_wdata = wd;
    #1;
    check({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else begin e.vld = 1'b0; e.owner = 1'b0; e.chkd = 1'b0; e.data = '0; end
    check({tag, "_m0_data_ok"}, m0_data_ok, e.vld && !e.owner);
    check({tag, "_m1_data_ok"}, m1_data_ok, e.vld && e.owner);
    if (e.vld && e.chkd)
      check({tag, "_rdata"}, e.owner ? m1_rdata : m0_rdata, e.data);
    g = mdl_grant(r0, r1);
    check({tag, "_m0_addr_ok"}, m0_addr_ok, g[0]);
    check({tag, "_m1_addr_ok"}, m1_addr_ok, g[1]);
    check({tag, "_sram_en"}, sram_en, |g);
    check({tag, "_sram_wen"}, sram_wen, (g[1] && wr) ? st : 4'b0000);
    if (|g) check({tag, "_sram_addr"}, sram_addr, g[1] ? a1 : a0);
    n.vld   = |g;
    n.owner = g[1];
    n.chkd  = !(g[1] && wr);
    n.data  = ref_rd(g[1] ? a1 : a0);
    if (g[1] && wr) begin
      logic [31:0] w;
      w = ref_rd(a1);
      for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[a1 >> 2] = w;
    end
    if (|g) mdl_last = g[1];
    exp_q.push_back(n);
  endtask

  initial begin
    mem[32'h1C000000 >> 2]     = 32'h02800C0C;
    ref_mem[32'h1C000000 >> 2] = 32'h02800C0C;

    // Reset state: a pending fetch request must not be accepted.
    m0_req = 1'b1; m0_addr = 32'h1C000000;
    @(negedge clk); #1;
    all_zero("reset");
    push_idle();

    // Single fetch, granted in the first cycle after release.
    step("fetch",   1, 1, 32'h1C000000, 0, 0, 4'h0, 32'h0, 32'h0);
    step("fetch_r", 0, 0, 32'h0,        0, 0, 4'h0, 32'h0, 32'h0);

    // Partial store then load of the same word.
    step("store",   0, 0, 32'h0, 1, 1, 4'b0011, 32'h100, 32'hDEADBEEF);
    step("load",    0, 0, 32'h0, 1, 0, 4'b0000, 32'h100, 32'h0);
    step("load_r",  0, 0, 32'h0, 0, 0, 4'b0000, 32'h0,   32'h0);
    check("load_const", m1_rdata, 32'h0000BEEF);

    // Contention for three cycles, then M1 drops.
    for (int i = 0; i < 3; i++)
      step("contend", 0, 1, 32'h1C000000, 1, 0, 4'h0, 32'h100, 32'h0);
    step("m0_after", 0, 1, 32'h1C000000, 0, 0, 4'h0, 32'h0, 32'h0);
    step("idle1",    0, 0, 32'h0,        0, 0, 4'h0, 32'h0, 32'h0);

    // Back-to-back mixed reads, plus an unwritten word.
    step("b2b_m0", 0, 1, 32'h1C000000, 0, 0, 4'h0, 32'h0,   32'h0);
    step("b2b_m1", 0, 0, 32'h0,        1, 0, 4'h0, 32'h100, 32'h0);
    step("b2b_m0z",0, 1, 32'h200,      0, 0, 4'h0, 32'h0,   32'h0);
    step("idle2",  0, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0);

    // Reset between an M0 grant and its response edge.
    step("pre_rst", 0, 1, 32'h1C000000, 0, 0, 4'h0, 32'h0, 32'h0);
    #2 reset = 1'b1;
    #1;
    all_zero("rst_async");
    @(posedge clk); #1;
    all_zero("rst_hold");
    exp_q.delete();
    mdl_last = 1'b0;
    push_idle();
    step("post_rst",   1, 1, 32'h1C000000, 0, 0, 4'h0, 32'h0, 32'h0);
    step("post_rst_r", 0, 0, 32'h0,        0, 0, 4'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
